// File: rtl/alu_control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the datapath.
// The sequencer drives every strobe; the datapath returns IR contents and memory-ready.
interface alu_control_sequencer_if #(
    parameter int OPW = 5
);
    logic [31:0]    ir;
    logic           mem_rdy;

    logic           PCout;
    logic           MARin;
    logic           IncPC;
    logic           PCin;
    logic           Read;
    logic           MDRin;
    logic           MDRout;
    logic           IRin;
    logic           Yin;
    logic           ZLOin;
    logic           ZHIin;
    logic           ZLowout;
    logic           ZHighout;
    logic           HIin;
    logic           LOin;
    logic           Gra;
    logic           Grb;
    logic           Grc;
    logic           Rin;
    logic           Rout;
    logic [OPW-1:0] operation;
    logic           instr_done;
    logic           illegal;
    logic           halted;

    modport master (
        input  ir, mem_rdy,
        output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
               Yin, ZLOin, ZHIin, ZLowout, ZHighout, HIin, LOin,
               Gra, Grb, Grc, Rin, Rout, operation, instr_done, illegal, halted
    );

    modport slave (
        output ir, mem_rdy,
        input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
               Yin, ZLOin, ZHIin, ZLowout, ZHighout, HIin, LOin,
               Gra, Grb, Grc, Rin, Rout, operation, instr_done, illegal, halted
    );
endinterface

// File: rtl/alu_control_sequencer.sv
// Hardwired control unit: fetch (T0-T2) then ALU-class execute steps (T3-T6).
// The state register is the only storage; all strobes are decoded from state, IR and mem_rdy.
module alu_control_sequencer #(
    parameter int OPW  = 5,
    parameter int REGW = 4
) (
    input  logic                      clk,
    input  logic                      clr,
    alu_control_sequencer_if.master   bus
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b01010);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01110);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01111);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10000);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);
    localparam int FIELD_LSB = 32 - OPW - 3*REGW;

    state_t         state;
    state_t         next_state;
    logic [OPW-1:0] opcode;
    logic           is_alu3;
    logic           is_muldiv;
    logic           is_negnot;
    logic           is_nop;
    logic           is_halt;
    logic           unused_ir_bits;

    assign opcode    = bus.ir[31 -: OPW];
    assign is_alu3   = (opcode >= OP_ADD) && (opcode <= OP_OR);
    assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign is_negnot = (opcode == OP_NEG) || (opcode == OP_NOT);
    assign is_nop    = (opcode == OP_NOP);
    assign is_halt   = (opcode == OP_HALT);

    // Ra/Rb/Rc are decoded inside the datapath through Gra/Grb/Grc.
    assign unused_ir_bits = ^{bus.ir[31-OPW:FIELD_LSB], bus.ir[FIELD_LSB-1:0]};

    // clr forces IDLE immediately, which in turn zeroes every strobe.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Strobe and next-state decode.
    always_comb begin
        next_state     = state;
        bus.PCout      = 1'b0;
        bus.MARin      = 1'b0;
        bus.IncPC      = 1'b0;
        bus.PCin       = 1'b0;
        bus.Read       = 1'b0;
        bus.MDRin      = 1'b0;
        bus.MDRout     = 1'b0;
        bus.IRin       = 1'b0;
        bus.Yin        = 1'b0;
        bus.ZLOin      = 1'b0;
        bus.ZHIin      = 1'b0;
        bus.ZLowout    = 1'b0;
        bus.ZHighout   = 1'b0;
        bus.HIin       = 1'b0;
        bus.LOin       = 1'b0;
        bus.Gra        = 1'b0;
        bus.Grb        = 1'b0;
        bus.Grc        = 1'b0;
        bus.Rin        = 1'b0;
        bus.Rout       = 1'b0;
        bus.operation  = '0;
        bus.instr_done = 1'b0;
        bus.illegal    = 1'b0;
        bus.halted     = 1'b0;

        case (state)
            IDLE: begin
                next_state = T0;
            end
            T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.ZLOin  = 1'b1;
                next_state = T1;
            end
            T1: begin
                // PC reload only in the completing cycle, so a long wait loads it once.
                bus.Read  = 1'b1;
                bus.MDRin = 1'b1;
                if (bus.mem_rdy) begin
                    bus.ZLowout = 1'b1;
                    bus.PCin    = 1'b1;
                    next_state  = T2;
                end
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                next_state = T3;
            end
            T3: begin
                if (is_alu3 || is_muldiv) begin
                    bus.Grb    = 1'b1;
                    bus.Rout   = 1'b1;
                    bus.Yin    = 1'b1;
                    next_state = T4;
                end else if (is_negnot) begin
                    bus.Grb       = 1'b1;
                    bus.Rout      = 1'b1;
                    bus.operation = opcode;
                    bus.ZLOin     = 1'b1;
                    next_state    = T4;
                end else if (is_nop) begin
                    bus.instr_done = 1'b1;
                    next_state     = T0;
                end else if (is_halt) begin
                    bus.instr_done = 1'b1;
                    next_state     = HALT;
                end else begin
                    bus.illegal    = 1'b1;
                    bus.instr_done = 1'b1;
                    next_state     = T0;
                end
            end
            T4: begin
                if (is_alu3 || is_muldiv) begin
                    bus.Grc       = 1'b1;
                    bus.Rout      = 1'b1;
                    bus.operation = opcode;
                    bus.ZLOin     = 1'b1;
                    bus.ZHIin     = is_muldiv;
                    next_state    = T5;
                end else if (is_negnot) begin
                    bus.ZLowout    = 1'b1;
                    bus.Gra        = 1'b1;
                    bus.Rin        = 1'b1;
                    bus.instr_done = 1'b1;
                    next_state     = T0;
                end else begin
                    next_state = T0;
                end
            end
            T5: begin
                if (is_alu3) begin
                    bus.ZLowout    = 1'b1;
                    bus.Gra        = 1'b1;
                    bus.Rin        = 1'b1;
                    bus.instr_done = 1'b1;
                    next_state     = T0;
                end else if (is_muldiv) begin
                    bus.ZLowout = 1'b1;
                    bus.LOin    = 1'b1;
                    next_state  = T6;
                end else begin
                    next_state = T0;
                end
            end
            T6: begin
                bus.ZHighout   = 1'b1;
                bus.HIin       = 1'b1;
                bus.instr_done = 1'b1;
                next_state     = T0;
            end
            HALT: begin
                bus.halted = 1'b1;
                next_state = HALT;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
